alu_sequencer: RTL and testbench

Two-requester round-robin front end for the shared ALU datapath. Accepts operation requests (operator plus two 32-bit operands) over valid/ready handshakes and latches the winning request. It drives the ALU's operand/operator inputs and a registered one-cycle `alu_req_o` pulse, which the ALU uses as its capture edge. After a fixed settle delay it samples the ALU result and returns it on a single tagged response channel. It is the only block allowed to drive the ALU's `req_i`.

---
 rtl/alu_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: two-requester round-robin front end for the shared ALU.
// It latches the winning request and drives the ALU with a one-cycle capture strobe.
// After a fixed settle delay it samples the ALU result and returns it on one tagged
// response channel.

package alu_pkg;
  // ALU operator encoding. ADD is zero so the reset operator is ADD.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op;
endpackage

module alu_sequencer #(
  parameter int WAIT_CYCLES = 1  // must be >= 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            in_valid_i,
  output logic [1:0]            in_ready_o,
  input  alu_pkg::alu_op [1:0]  in_op_i,
  input  logic [1:0][31:0]      in_a_i,
  input  logic [1:0][31:0]      in_b_i,
  output logic                  alu_req_o,
  output alu_pkg::alu_op        alu_op_o,
  output logic [31:0]           alu_a_o,
  output logic [31:0]           alu_b_o,
  input  logic [31:0]           alu_result_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_id_o,
  output logic [31:0]           rsp_data_o
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic            r_prio;
  logic [CW-1:0]   r_cnt;
  logic            r_alu_req;
  alu_pkg::alu_op  r_op;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic            r_rsp_valid;
  logic            r_rsp_id;
  logic [31:0]     r_rsp_data;

  logic            w_any_valid;
  logic            w_gnt_id;
  logic            w_grant;

  // Arbitration: a lone requester wins; on contention the priority pointer decides.
  always_comb begin
    w_any_valid = |in_valid_i;
    w_gnt_id    = (in_valid_i == 2'b11) ? r_prio : in_valid_i[1];
    w_grant     = (r_state == S_IDLE) && w_any_valid && !rst_i;
    in_ready_o  = w_grant ? (2'b01 << w_gnt_id) : 2'b00;
  end

  // Sequencer FSM. It latches the granted payload, pulses the ALU strobe, waits
  // for the result to settle and then holds the response until it is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_cnt       <= '0;
      r_alu_req   <= 1'b0;
      r_op        <= alu_pkg::ALU_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_alu_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_op      <= in_op_i[w_gnt_id];
            r_a       <= in_a_i[w_gnt_id];
            r_b       <= in_b_i[w_gnt_id];
            r_rsp_id  <= w_gnt_id;
            r_prio    <= ~w_gnt_id;
            r_alu_req <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == LAST_CNT) begin
            r_rsp_data  <= alu_result_i;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_req_o   = r_alu_req;
  assign alu_op_o    = r_op;
  assign alu_a_o     = r_a;
  assign alu_b_o     = r_b;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_data_o  = r_rsp_data;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. It uses a scoreboard that is fed at grant time and
// checked by a cycle monitor. It also contains a behavioural ALU and a reference
// model of grant, latency and backpressure behaviour.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int W = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  alu_op [1:0]      in_op;
  logic [1:0][31:0] in_a;
  logic [1:0][31:0] in_b;
  logic             alu_req;
  alu_op            alu_op_s;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [31:0]      rsp_data;

  // Second instance with a longer settle delay.
  logic [1:0]       in_valid3, in_ready3;
  alu_op [1:0]      in_op3;
  logic [1:0][31:0] in_a3, in_b3;
  logic             alu_req3;
  alu_op            alu_op3;
  logic [31:0]      alu_a3, alu_b3, alu_result3;
  logic             rsp_valid3, rsp_id3;
  logic [31:0]      rsp_data3;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic        id;
    alu_op       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } item_t;

  item_t sb[$];
  logic  grant_log[$];
  logic  busy   = 1'b0;
  logic  prio   = 1'b0;
  int    g_cyc  = 0;

  alu_sequencer #(.WAIT_CYCLES(W)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b),
    .alu_req_o(alu_req), .alu_op_o(alu_op_s), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data)
  );

  alu_sequencer #(.WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3),
    .in_op_i(in_op3), .in_a_i(in_a3), .in_b_i(in_b3),
    .alu_req_o(alu_req3), .alu_op_o(alu_op3), .alu_a_o(alu_a3), .alu_b_o(alu_b3),
    .alu_result_i(alu_result3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(1'b1),
    .rsp_id_o(rsp_id3), .rsp_data_o(rsp_data3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(alu_op op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      default:  return 32'h0;
    endcase
  endfunction

  // Behavioural ALUs: capture on the strobe, result available the following cycle.
  initial begin alu_result = '0; alu_result3 = '0; end
  always @(posedge clk) if (alu_req)  alu_result  <= alu_f(alu_op_s, alu_a, alu_b);
  always @(posedge clk) if (alu_req3) alu_result3 <= alu_f(alu_op3, alu_a3, alu_b3);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / reference model, evaluated away from the active edge.
  always @(negedge clk) begin
    logic [1:0] exp_rdy, hs;
    logic       g;
    item_t      it;
    if (rst) begin
      busy = 1'b0;
      prio = 1'b0;
      sb.delete();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_alu_req", 32'(alu_req), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu_op", 32'(alu_op_s), 32'(ALU_ADD));
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    end else begin
      if (busy) exp_rdy = 2'b00;
      else if (in_valid == 2'b11) exp_rdy = prio ? 2'b10 : 2'b01;
      else exp_rdy = in_valid;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("alu_req", 32'(alu_req), 32'(busy && cyc == g_cyc + 1));
      chk("rsp_valid", 32'(rsp_valid), 32'(busy && cyc >= g_cyc + 2 + W));
      if (busy && sb.size() > 0) begin
        chk("alu_op", 32'(alu_op_s), 32'(sb[0].op));
        chk("alu_a", alu_a, sb[0].a);
        chk("alu_b", alu_b, sb[0].b);
        if (rsp_valid) begin
          chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          chk("rsp_data", rsp_data, sb[0].res);
        end
      end
      if (busy && rsp_valid && rsp_ready) begin
        $display("rsp id=%0d data=%h cycle=%0d", rsp_id, rsp_data, cyc);
        if (sb.size() > 0) void'(sb.pop_front());
        busy = 1'b0;
      end
      hs = exp_rdy & in_valid;
      if (hs != 2'b00) begin
        g = hs[1];
        it.id = g; it.op = in_op[g]; it.a = in_a[g]; it.b = in_b[g];
        it.res = alu_f(in_op[g], in_a[g], in_b[g]);
        sb.push_back(it);
        grant_log.push_back(g);
        prio  = ~g;
        busy  = 1'b1;
        g_cyc = cyc;
      end
    end
  end

  // One requester presents a request, holds it until accepted, then scrambles its payload.
  task automatic do_req(int id, alu_op op, logic [31:0] a, logic [31:0] b);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid[id] = 1'b1; in_op[id] = op; in_a[id] = a; in_b[id] = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready[id]) begin ok = 1; break; end
    end
    chk("grant_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid[id] = 1'b0;
    in_a[id] = $urandom;
    in_b[id] = $urandom;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin ok = 1; break; end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    int t;
    logic [1:0] acc;
    rst = 1'b1; in_valid = '0; in_op = '{ALU_ADD, ALU_ADD}; in_a = '0; in_b = '0;
    rsp_ready = 1'b1;
    in_valid3 = '0; in_op3 = '{ALU_ADD, ALU_ADD}; in_a3 = '0; in_b3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single ADD request from requester 0.
    do_req(0, ALU_ADD, 32'd5, 32'd7);
    wait_idle();

    // Backpressure while the response is pending.
    rsp_ready = 1'b0;
    do_req(1, ALU_OR, 32'h1234_0000, 32'h0000_5678);
    repeat (8) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle();

    // Both requesters valid continuously: grants must alternate.
    grant_log.delete();
    @(posedge clk); #1;
    in_op[0] = ALU_SUB; in_a[0] = 32'd10;   in_b[0] = 32'd3;
    in_op[1] = ALU_XOR; in_a[1] = 32'hF0;   in_b[1] = 32'hFF;
    in_valid = 2'b11;
    for (int i = 0; i < 100 && grant_log.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1 in_valid = 2'b00;
    chk("alt_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("alt_grant", 32'(grant_log[i]), 32'(i % 2));
    wait_idle();

    // Reset asserted while waiting on the ALU.
    do_req(0, ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rst_now_alu_req", 32'(alu_req), 32'd0);
    chk("rst_now_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_now_alu_a", alu_a, 32'd0);
    chk("rst_now_alu_b", alu_b, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    do_req(1, ALU_SRA, 32'h8000_0000, 32'd4);
    wait_idle();

    // Randomized traffic with random response backpressure.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !in_valid[i]) begin
          in_valid[i] = ($urandom_range(0, 2) == 0);
          in_op[i]    = alu_op'($urandom_range(0, 9));
          in_a[i]     = $urandom;
          in_b[i]     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 in_valid = '0; rsp_ready = 1'b1;
    wait_idle();

    // Longer settle delay: SLTU 1,2 from requester 1 responds at T+5.
    @(posedge clk); #1;
    in_valid3[1] = 1'b1; in_op3[1] = ALU_SLTU; in_a3[1] = 32'd1; in_b3[1] = 32'd2;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready3[1]) begin ok = 1; break; end
    end
    chk("w3_grant", 32'(ok), 32'd1);
    t = cyc;
    @(posedge clk); #1 in_valid3 = '0; in_a3[1] = 32'd99;
    @(negedge clk);
    chk("w3_alu_req", 32'(alu_req3), 32'd1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid3) begin ok = 1; break; end
    end
    chk("w3_rsp_seen", 32'(ok), 32'd1);
    chk("w3_latency", 32'(cyc - t), 32'd5);
    chk("w3_data", rsp_data3, 32'd1);
    chk("w3_id", 32'(rsp_id3), 32'd1);
    $display("rsp3 id=%0d data=%h cycle=%0d", rsp_id3, rsp_data3, cyc);
    @(negedge clk);
    chk("w3_rsp_done", 32'(rsp_valid3), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
